// File: rtl/wb_arbiter.sv
// wb_arbiter: shares the register-file write port between the in-order
// write-back stage (P) and a long-latency result FIFO (F).
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   halted               pipeline frozen this cycle
//   rd_valid_w/rd_w/reg_d_w   W-stage register write
//   lr_valid/lr_rd/lr_data    long-latency result offer; lr_ready accepts it
//   rs1_d, rs2_d         decode sources; lr_hazard flags a pending FIFO write
//   we/wa/wd             register-file write port
//   wb_stall             pipeline write denied; pipeline must freeze
//
// Optional feature macro: WB_BYPASS_EN -- when the FIFO is empty and the
// pipeline is idle, an accepted result is written in its accept cycle
// instead of being queued.
module wb_arbiter #(
    parameter int DEPTH   = 2,
    parameter int AGE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        halted,
    input  logic        rd_valid_w,
    input  logic [4:0]  rd_w,
    input  logic [31:0] reg_d_w,
    input  logic        lr_valid,
    input  logic [4:0]  lr_rd,
    input  logic [31:0] lr_data,
    output logic        lr_ready,
    input  logic [4:0]  rs1_d,
    input  logic [4:0]  rs2_d,
    output logic        lr_hazard,
    output logic        we,
    output logic [4:0]  wa,
    output logic [31:0] wd,
    output logic        wb_stall
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(AGE_MAX + 1);

    typedef struct packed {
        logic        vld;
        logic [4:0]  rd;
        logic [31:0] data;
    } lr_entry_t;

    lr_entry_t       fifo [DEPTH];
    logic [PW-1:0]   head, tail;
    logic [CW-1:0]   count;
    logic [AW-1:0]   age;

    logic p_req, f_req, full, age_max, waw, hit;
    logic enq, bypass, push, pop, grant_f, grant_p;

    assign p_req   = rd_valid_w && (rd_w != 5'd0);
    assign f_req   = (count != '0);
    assign full    = (count == CW'(DEPTH));
    assign age_max = (age == AW'(AGE_MAX));

    assign lr_ready = !full && !reset;
    // x0 results complete the handshake but are never stored or written.
    assign enq      = lr_valid && lr_ready && (lr_rd != 5'd0);

    // Entries never hold rd=0, so only the decode side needs the x0 guard.
    always_comb begin
        waw = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (fifo[i].vld && fifo[i].rd == rd_w) waw = 1'b1;
            if (fifo[i].vld && ((rs1_d != 5'd0 && fifo[i].rd == rs1_d) ||
                                (rs2_d != 5'd0 && fifo[i].rd == rs2_d)))
                hit = 1'b1;
        end
        waw = waw && p_req;
    end

    assign lr_hazard = hit && !reset;

    // The head must win when the pipeline cannot be allowed past it:
    // full queue, older pending write to the same register, starvation,
    // or a frozen pipeline that will replay its write anyway.
    assign grant_f = f_req && (full || waw || age_max || halted || !p_req);
    assign grant_p = p_req && !grant_f;

`ifdef WB_BYPASS_EN
    assign bypass = enq && !f_req && !p_req;
`else
    assign bypass = 1'b0;
`endif

    assign push = enq && !bypass;
    assign pop  = grant_f && !reset;

    always_comb begin
        we = 1'b0;
        wa = 5'd0;
        wd = 32'd0;
        if (!reset) begin
            if (grant_f) begin
                we = 1'b1;
                wa = fifo[head].rd;
                wd = fifo[head].data;
            end else if (grant_p) begin
                we = 1'b1;
                wa = rd_w;
                wd = reg_d_w;
            end else if (bypass) begin
                we = 1'b1;
                wa = lr_rd;
                wd = lr_data;
            end
        end
    end

    assign wb_stall = !reset && p_req && grant_f && !halted;

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            age   <= '0;
            for (int i = 0; i < DEPTH; i++) fifo[i] <= '0;
        end else begin
            // push and pop never touch the same slot: pop needs count>0,
            // push needs count<DEPTH, so head != tail whenever both fire.
            if (push) begin
                fifo[tail] <= '{vld: 1'b1, rd: lr_rd, data: lr_data};
                tail       <= tail + PW'(1);
            end
            if (pop) begin
                fifo[head].vld <= 1'b0;
                head           <= head + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (pop || !f_req)
                age <= '0;
            else if (grant_p && !age_max)
                age <= age + AW'(1);
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter (DEPTH=2, AGE_MAX=4). Stimulus pushes each
// expected register-file write into a queue; a monitor pops and compares on
// every cycle the DUT asserts we.
module tb_wb_arbiter;
    logic        clk = 1'b0;
    logic        reset, halted, rd_valid_w, lr_valid;
    logic [4:0]  rd_w, lr_rd, rs1_d, rs2_d, wa;
    logic [31:0] reg_d_w, lr_data, wd;
    logic        lr_ready, lr_hazard, we, wb_stall;

    wb_arbiter #(.DEPTH(2), .AGE_MAX(4)) dut (
        .clk(clk), .reset(reset), .halted(halted),
        .rd_valid_w(rd_valid_w), .rd_w(rd_w), .reg_d_w(reg_d_w),
        .lr_valid(lr_valid), .lr_rd(lr_rd), .lr_data(lr_data), .lr_ready(lr_ready),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .lr_hazard(lr_hazard),
        .we(we), .wa(wa), .wd(wd), .wb_stall(wb_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        st;
    } exp_t;

    exp_t        sbq[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] rf7   = 32'd0;
    bit          wr12  = 1'b0;

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!reset && we) begin
            n_cmp++;
            if (wa == 5'd7)  rf7 = wd;
            if (wa == 5'd12) wr12 = 1'b1;
            if (sbq.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: got wa=%0d wd=%h stall=%b, required no write",
                         wa, wd, wb_stall);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                if (wa !== e.wa || wd !== e.wd || wb_stall !== e.st) begin
                    n_err++;
                    $display("FAIL write: got wa=%0d wd=%h stall=%b, required wa=%0d wd=%h stall=%b",
                             wa, wd, wb_stall, e.wa, e.wd, e.st);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                          input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
        rd_valid_w = pv; rd_w = prd; reg_d_w = pd;
        lr_valid = lv; lr_rd = lrd; lr_data = ld;
    endtask

    task automatic expw(input logic [4:0] a, input logic [31:0] d, input logic st);
        exp_t e;
        e.wa = a; e.wd = d; e.st = st;
        sbq.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    initial begin
        reset = 1'b1; halted = 1'b0; rs1_d = 5'd0; rs2_d = 5'd0;
        set_in(0, 0, 0, 1, 9, 32'h99);

        // Reset then idle
        tick(); tick(); #1;
        chk("rst_lr_ready", lr_ready, 0);
        chk("rst_we", we, 0);
        chk("rst_stall", wb_stall, 0);
        chk("rst_hazard", lr_hazard, 0);
        tick();
        reset = 1'b0; set_in(0, 0, 0, 0, 0, 0); rs1_d = 5'd9; #1;
        chk("idle_hazard", lr_hazard, 0);
        chk("idle_lr_ready", lr_ready, 1);
        chk("idle_we", we, 0);
        rs1_d = 5'd0;

        // Single enqueue, pipeline idle
        tick(); set_in(0, 0, 0, 1, 5, 32'h1234); expw(5, 32'h1234, 0); #1;
`ifdef WB_BYPASS_EN
        chk("enq_accept_we", we, 1);
`else
        chk("enq_accept_we", we, 0);
`endif
        tick(); set_in(0, 0, 0, 0, 0, 0); #1;
`ifdef WB_BYPASS_EN
        chk("enq_next_we", we, 0);
`else
        chk("enq_next_we", we, 1);
`endif
        tick(); #1;
        chk("enq_drained_we", we, 0);

        // Starvation: x6 queued behind back-to-back pipeline writes
        tick(); set_in(1, 1, 32'h101, 1, 6, 32'h66); expw(1, 32'h101, 0);
        for (int i = 2; i <= 5; i++) begin
            tick(); set_in(1, 5'(i), 32'h100 + 32'(i), 0, 0, 0); expw(5'(i), 32'h100 + 32'(i), 0);
            #1; chk("starve_p_stall", wb_stall, 0);
        end
        tick(); set_in(1, 7, 32'h107, 0, 0, 0); expw(6, 32'h66, 1); #1;
        chk("starve_forced_stall", wb_stall, 1);
        tick(); expw(7, 32'h107, 0); #1;
        chk("starve_resume_stall", wb_stall, 0);
        tick(); set_in(1, 8, 32'h108, 0, 0, 0); expw(8, 32'h108, 0);
        tick(); set_in(1, 9, 32'h109, 0, 0, 0); expw(9, 32'h109, 0);
        tick(); set_in(0, 0, 0, 0, 0, 0);

        // WAW ordering on x7
        tick(); set_in(1, 2, 32'h22, 1, 7, 32'hAAAA); expw(2, 32'h22, 0);
        tick(); set_in(1, 7, 32'hBBBB, 0, 0, 0); expw(7, 32'hAAAA, 1); #1;
        chk("waw_stall", wb_stall, 1);
        tick(); expw(7, 32'hBBBB, 0); #1;
        chk("waw_resume_stall", wb_stall, 0);
        tick(); set_in(0, 0, 0, 0, 0, 0);

        // Full FIFO, then x0 discard
        tick(); set_in(1, 1, 32'h11, 1, 3, 32'h33); expw(1, 32'h11, 0);
        tick(); set_in(1, 2, 32'h21, 1, 4, 32'h44); expw(2, 32'h21, 0); #1;
        chk("fill_lr_ready", lr_ready, 1);
        tick(); set_in(1, 8, 32'h88, 1, 10, 32'hA0); expw(3, 32'h33, 1); #1;
        chk("full_lr_ready", lr_ready, 0);
        chk("full_stall", wb_stall, 1);
        tick(); set_in(1, 8, 32'h88, 0, 0, 0); expw(8, 32'h88, 0); #1;
        chk("full_resume_stall", wb_stall, 0);
        tick(); set_in(0, 0, 0, 0, 0, 0); expw(4, 32'h44, 0);
        tick(); set_in(0, 0, 0, 1, 0, 32'hDEAD); #1;
        chk("x0_lr_ready", lr_ready, 1);
        chk("x0_we", we, 0);
        tick(); set_in(0, 0, 0, 0, 0, 0); #1;
        chk("x0_next_we", we, 0);

        // Hazard, then reset discards the queued x12
        tick(); set_in(1, 2, 32'h222, 1, 12, 32'hC); rs1_d = 5'd12; expw(2, 32'h222, 0); #1;
        chk("haz_before_enq", lr_hazard, 0);
        tick(); set_in(1, 13, 32'hD, 0, 0, 0); expw(13, 32'hD, 0); #1;
        chk("haz_rs1", lr_hazard, 1);
        rs1_d = 5'd0; rs2_d = 5'd12; #1;
        chk("haz_rs2", lr_hazard, 1);
        rs2_d = 5'd0; #1;
        chk("haz_x0", lr_hazard, 0);
        rs1_d = 5'd12;
        tick(); reset = 1'b1; set_in(1, 14, 32'hE, 0, 0, 0); #1;
        chk("midrst_we", we, 0);
        chk("midrst_stall", wb_stall, 0);
        chk("midrst_hazard", lr_hazard, 0);
        chk("midrst_lr_ready", lr_ready, 0);
        tick(); reset = 1'b0; set_in(0, 0, 0, 0, 0, 0); #1;
        chk("postrst_hazard", lr_hazard, 0);
        chk("postrst_we", we, 0);
        tick(); #1;
        chk("postrst_idle_we", we, 0);

        tick(); tick();
        chk("sb_drained", 32'(sbq.size()), 0);
        chk("final_x7", rf7, 32'hBBBB);
        chk("x12_never_written", 32'(wr12), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Arbiter for the register-file write port. It sits after the MEM/WB pipeline register and shares the single write port between the in-order write-back stage and a long-latency unit (divider/multi-cycle load) that returns results out of band. Long-latency results are buffered in a small FIFO. The block requests a pipeline freeze when the pipeline write must yield. It also exports a pending-destination hazard check for decode.

## Interface
Parameters:
- DEPTH, 2, long-latency result FIFO entries; power of two, ≥2.
- AGE_MAX, 4, consecutive cycles the FIFO head may lose arbitration before it is forced to win; ≥1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- halted  in  1  pipeline frozen this cycle; the W stage holds its contents.
- rd_valid_w  in  1  W stage has a register write.
- rd_w  in  5  W stage destination register.
- reg_d_w  in  32  W stage write data.
- lr_valid  in  1  long-latency result offered.
- lr_rd  in  5  long-latency destination register.
- lr_data  in  32  long-latency result data.
- lr_ready  out  1  result accepted this cycle when lr_valid is also high.
- rs1_d, rs2_d  in  5 each  decode-stage source registers.
- lr_hazard  out  1  rs1_d or rs2_d (nonzero) matches a valid FIFO entry.
- we  out  1  register-file write enable.
- wa  out  5  register-file write address.
- wd  out  32  register-file write data.
- wb_stall  out  1  pipeline write denied this cycle; the pipeline must freeze (drive halted).

## Operation
- Pipeline request (P): rd_valid_w & (rd_w≠0).
- FIFO head request (F): count≠0.
- Enqueue: lr_valid & lr_ready & (lr_rd≠0). When lr_rd=0, the handshake completes and the result is discarded.
- lr_ready = (count<DEPTH) & ~reset.
- WAW match: P and rd_w equals the rd of any valid FIFO entry.
- Grant to F when F and any of the following holds:
  - count=DEPTH
  - WAW match
  - age=AGE_MAX
  - halted
  - ~P
- Otherwise grant to P if P.
- When F is granted: we=1, wa/wd = head entry, head pops at the clock edge.
- When P is granted: we=1, wa=rd_w, wd=reg_d_w.
- Otherwise we=0. wa and wd are don't-care when we=0.
- wb_stall = P & F granted & ~halted.
- Age counter: increments when F is high and P is granted, saturating at AGE_MAX. Clears on head pop or when count=0.
- Push and pop in the same cycle are both performed; count is unchanged; the full condition is evaluated on the pre-edge count.
- Pipeline writes repeated during halted cycles are permitted, because the write is idempotent.
- lr_hazard is combinational from FIFO contents and rs1_d/rs2_d. x0 never hits.

## Timing
- Reset values: count=0, age=0, FIFO entries invalid, head/tail pointers 0.
- While reset is high, the block forces we=0, wb_stall=0, lr_ready=0 and lr_hazard=0.
- we/wa/wd/wb_stall/lr_ready are combinational from state and the current-cycle inputs; there are no output registers.
- Long-latency result latency (no bypass): accepted at edge N, earliest write in cycle N+1.
- Pipeline write latency: same cycle as presented in W, unless stalled.
- Worst-case wait of a FIFO head behind continuous pipeline writes: AGE_MAX cycles, then one stall cycle.
- Reset asserted mid-operation discards all FIFO contents; no write issues in the reset cycle.

## Configuration
- WB_BYPASS_EN defined:
  - Applies when count=0, ~P and an enqueue occurs.
  - The result is written directly that cycle: we=1, wa=lr_rd, wd=lr_data.
  - The result is not enqueued; count stays 0.
  - lr_hazard does not see bypassed entries.
- WB_BYPASS_EN undefined: every accepted result is enqueued, with minimum 1-cycle latency to the port.

## Test plan
- Reset then idle: with reset=1 and lr_valid=1, lr_ready=0 and we=0. After reset deasserts, count=0 and lr_hazard=0.
- Enqueue x5=0x1234, then pipeline idle:
  - Without bypass: we=1, wa=5, wd=0x1234 in the next cycle.
  - With bypass: the same write occurs in the accept cycle.
- Starvation: x6 queued while P writes x1..x9 back-to-back with AGE_MAX=4. P wins 4 cycles, then cycle 5 writes x6 with wb_stall=1, and P resumes in cycle 6.
- WAW: FIFO holds x7=0xAAAA and P writes x7=0xBBBB. Cycle 1 writes 0xAAAA with wb_stall=1; cycle 2 writes 0xBBBB. Final x7=0xBBBB.
- Full and x0: with DEPTH=2, enqueue x3 and x4 while P is busy → lr_ready=0, and the next P cycle stalls. An enqueue with lr_rd=0 never produces we=1.
- Hazard plus reset: with x12 queued and rs1_d=12, lr_hazard=1. Assert reset for 1 cycle → lr_hazard=0 and no write to x12 occurs.
